hbridge_chopper: RTL

HBRIDGE_CHOPPER -- requirements
Module: hbridge_chopper

---
 rtl/hbridge_chopper_pkg.sv | 56 +++++
 rtl/hbridge_chopper_timer.sv | 43 ++++
 rtl/hbridge_chopper.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/hbridge_chopper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hbridge_chopper_pkg
// Description : Shared constants for the H-bridge peak-current chopper:
//               FSM state codes, DEAD-exit destination codes and the gate
//               patterns driven in each state.
//               Gate bus bit order everywhere is {s_l1, s_h1, s_l2, s_h2}.
// Revision    : 1.0 - initial release
// ============================================================================
package hbridge_chopper_pkg;

    // FSM state codes (also visible on the state output port)
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_dead  = 3'd1;
    localparam logic [2:0] c_st_blank = 3'd2;
    localparam logic [2:0] c_st_on    = 3'd3;
    localparam logic [2:0] c_st_off   = 3'd4;

    // Where DEAD goes when its timer expires
    localparam logic [1:0] c_nxt_idle  = 2'd0;
    localparam logic [1:0] c_nxt_blank = 2'd1;
    localparam logic [1:0] c_nxt_off   = 2'd2;

    // Gate patterns, {s_l1, s_h1, s_l2, s_h2}
    localparam logic [3:0] c_gates_off   = 4'b0000;
    localparam logic [3:0] c_gates_fwd   = 4'b0110;  // s_h1 + s_l2
    localparam logic [3:0] c_gates_rev   = 4'b1001;  // s_h2 + s_l1
    localparam logic [3:0] c_gates_decay = 4'b1010;  // both lows: slow decay

    // Gate pattern for a state. No pattern ever pairs a high and low
    // switch of the same leg, so a registered copy can never shoot through.
    function automatic logic [3:0] gate_map(input logic [2:0] st, input logic d);
        logic [3:0] g;
        g = c_gates_off;
        case (st)
            c_st_blank, c_st_on: g = d ? c_gates_rev : c_gates_fwd;
            c_st_off:            g = c_gates_decay;
            default:             g = c_gates_off;
        endcase
        return g;
    endfunction

    // Translate a DEAD destination code into the state it enters
    function automatic logic [2:0] nxt_to_state(input logic [1:0] n);
        logic [2:0] s;
        s = c_st_idle;
        case (n)
            c_nxt_blank: s = c_st_blank;
            c_nxt_off:   s = c_st_off;
            default:     s = c_st_idle;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hbridge_chopper_timer.sv
`default_nettype none
// ============================================================================
// Module      : chop_timer
// Description : Shared phase timer. A load captures the phase duration
//               (0 is promoted to 1); the count then steps down once per
//               cycle and saturates at zero. done is high in the last cycle
//               of the phase, so a phase loaded with N lasts exactly N cycles.
// Ports       : clk, rst        - clock / synchronous active-high reset
//               i_load          - capture i_load_val this edge
//               i_load_val      - phase length in cycles
//               o_done          - current cycle is the final one of the phase
// Revision    : 1.0 - initial release
// ============================================================================
module chop_timer #(
    parameter int TMR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_done
);

    localparam logic [TMR_W-1:0] c_zero = '0;
    localparam logic [TMR_W-1:0] c_one  = {{(TMR_W-1){1'b0}}, 1'b1};

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= c_zero;
        end else if (i_load) begin
            r_cnt <= (i_load_val == c_zero) ? c_one : i_load_val;
        end else if (r_cnt != c_zero) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    // Treating 0 as done as well guarantees no timed state can stall.
    assign o_done = (r_cnt <= c_one);

endmodule
`default_nettype wire

// File: rtl/hbridge_chopper.sv
`default_nettype none
// ============================================================================
// Module      : hbridge_chopper
// Description : Peak-current chopper for a full H-bridge. Drives the coil in
//               the latched direction until current reaches target (or the
//               on-time limit expires), then slow-decays for off_time, with
//               a DEAD gap around every switch-pattern change.
// Ports       : clk, reset                - clock / sync active-high reset
//               enable, dir               - run request, 0 fwd / 1 reverse
//               target, current           - peak setpoint / measured current
//               dead_time, blank_time,
//               off_time, max_on_time     - phase lengths in clk cycles
//               s_l1, s_h1, s_l2, s_h2    - registered bridge gates
//               state                     - FSM state code
//               trip, max_on              - one-cycle chop-reason pulses
// Revision    : 1.0 - initial release
// ============================================================================
module hbridge_chopper #(
    parameter int CUR_W = 13,
    parameter int TMR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic [CUR_W-1:0] target,
    input  logic [CUR_W-1:0] current,
    input  logic [TMR_W-1:0] dead_time,
    input  logic [TMR_W-1:0] blank_time,
    input  logic [TMR_W-1:0] off_time,
    input  logic [TMR_W-1:0] max_on_time,
    output logic             s_l1,
    output logic             s_h1,
    output logic             s_l2,
    output logic             s_h2,
    output logic [2:0]       state,
    output logic             trip,
    output logic             max_on
);

    import hbridge_chopper_pkg::*;

    logic [2:0]       r_state;
    logic [1:0]       r_nxt;
    logic             r_dir;
    logic [3:0]       r_gates;
    logic             r_trip;
    logic             r_max_on;

    logic [2:0]       w_next_state;
    logic [1:0]       w_next_nxt;
    logic [1:0]       w_dest;
    logic             w_run;
    logic             w_trip;
    logic             w_max_on;
    logic             w_load;
    logic [TMR_W-1:0] w_load_val;
    logic             w_tmr_done;

    assign w_run = enable && (target != '0);

    // ------------------------------------------------------------------
    // Next-state logic. Losing the run request beats every other exit
    // from a driving state; inside DEAD it redirects the exit to IDLE,
    // including when the dead timer expires in that same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_nxt   = r_nxt;
        w_dest       = r_nxt;
        w_trip       = 1'b0;
        w_max_on     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_run) begin
                    w_next_state = c_st_dead;
                    w_next_nxt   = c_nxt_blank;
                end
            end
            c_st_dead: begin
                if (!w_run) begin
                    w_dest     = c_nxt_idle;
                    w_next_nxt = c_nxt_idle;
                end
                if (w_tmr_done) begin
                    w_next_state = nxt_to_state(w_dest);
                end
            end
            c_st_blank: begin
                if (!w_run) begin
                    w_next_state = c_st_dead;
                    w_next_nxt   = c_nxt_idle;
                end else if (w_tmr_done) begin
                    w_next_state = c_st_on;
                end
            end
            c_st_on: begin
                if (!w_run) begin
                    w_next_state = c_st_dead;
                    w_next_nxt   = c_nxt_idle;
                end else if (current >= target) begin
                    // current limit has priority over a coincident timeout
                    w_next_state = c_st_dead;
                    w_next_nxt   = c_nxt_off;
                    w_trip       = 1'b1;
                end else if (w_tmr_done) begin
                    w_next_state = c_st_dead;
                    w_next_nxt   = c_nxt_off;
                    w_max_on     = 1'b1;
                end
            end
            c_st_off: begin
                if (!w_run) begin
                    w_next_state = c_st_dead;
                    w_next_nxt   = c_nxt_idle;
                end else if (w_tmr_done) begin
                    w_next_state = c_st_dead;
                    w_next_nxt   = c_nxt_blank;
                end
            end
            default: begin
                w_next_state = c_st_idle;
                w_next_nxt   = c_nxt_idle;
            end
        endcase
    end

    // Every state change is an entry into a new phase, so the timer
    // reloads exactly then with that phase's configured length.
    assign w_load = (w_next_state != r_state);

    always_comb begin
        w_load_val = '0;
        case (w_next_state)
            c_st_dead:  w_load_val = dead_time;
            c_st_blank: w_load_val = blank_time;
            c_st_on:    w_load_val = max_on_time;
            c_st_off:   w_load_val = off_time;
            default:    w_load_val = '0;
        endcase
    end

    chop_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_tmr_done)
    );

    // ------------------------------------------------------------------
    // State and output registers. Gates follow the *present* state, so
    // pins lag the state code by one cycle and never see current
    // combinationally. Reset clears the gates on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_nxt    <= c_nxt_idle;
            r_dir    <= 1'b0;
            r_gates  <= c_gates_off;
            r_trip   <= 1'b0;
            r_max_on <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_nxt    <= w_next_nxt;
            if ((r_state == c_st_dead) && (w_next_state == c_st_blank)) begin
                r_dir <= dir;
            end
            r_gates  <= gate_map(r_state, r_dir);
            r_trip   <= w_trip;
            r_max_on <= w_max_on;
        end
    end

    assign {s_l1, s_h1, s_l2, s_h2} = r_gates;
    assign state  = r_state;
    assign trip   = r_trip;
    assign max_on = r_max_on;

endmodule
`default_nettype wire
